// File: rtl/hmac_verify_pkg.sv
// Shared types and sizes for the HMAC-SHA256 tag verifier.
package hmac_verify_pkg;

  typedef enum logic [2:0] {IDLE, ERRCHK, CLEAR, RUN, CMP, RESP} state_t;

  localparam int HMAC_BYTES = 32;
  localparam int KEY_W      = 512;
  localparam int DATA_W     = 512;
  localparam int TAG_W      = 256;

  // Timeout counter width; a one-cycle budget still needs a 1-bit counter.
  function automatic int cnt_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/hmac_sha256.sv
// Single-block HMAC-SHA256 engine: key block plus one pre-padded message block.
// Four compressions (K^ipad, data, K^opad, inner digest) at one round per cycle.
module hmac_sha256 (
  input  logic         CLK,
  input  logic         RST,
  input  logic         go,
  input  logic [511:0] key,
  input  logic [511:0] data,
  output logic         data_available,
  output logic [255:0] hmac
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ROUND, S_ADD, S_DONE} core_state_t;

  localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  core_state_t st_reg, st_next;
  logic [1:0]   blk_reg;
  logic [5:0]   rnd_reg;
  logic [31:0]  hv_reg [8];
  logic [31:0]  wv_reg [8];
  logic [31:0]  w_reg  [16];
  logic [255:0] inner_reg, hmac_reg;

  logic [511:0] blk_data;
  logic [31:0]  blk_word [16];
  logic [31:0]  hsum [8];
  logic [255:0] hsum_flat;
  logic [31:0]  s0, s1, ch, maj, t1, t2, w_new;

  // Outer second block: inner digest, 0x80 pad, length 768 bits (64 + 32 bytes).
  always_comb begin
    case (blk_reg)
      2'd0:    blk_data = key ^ {64{8'h36}};
      2'd1:    blk_data = data;
      2'd2:    blk_data = key ^ {64{8'h5c}};
      default: blk_data = {inner_reg, 8'h80, 184'd0, 64'd768};
    endcase
  end

  genvar gi;
  for (gi = 0; gi < 16; gi++) begin : g_word
    assign blk_word[gi] = blk_data[511-32*gi -: 32];
  end
  for (gi = 0; gi < 8; gi++) begin : g_sum
    assign hsum[gi] = hv_reg[gi] + wv_reg[gi];
    assign hsum_flat[255-32*gi -: 32] = hsum[gi];
  end

  always_comb begin
    s1    = rotr(wv_reg[4], 6) ^ rotr(wv_reg[4], 11) ^ rotr(wv_reg[4], 25);
    ch    = (wv_reg[4] & wv_reg[5]) ^ (~wv_reg[4] & wv_reg[6]);
    t1    = wv_reg[7] + s1 + ch + K[rnd_reg] + w_reg[0];
    s0    = rotr(wv_reg[0], 2) ^ rotr(wv_reg[0], 13) ^ rotr(wv_reg[0], 22);
    maj   = (wv_reg[0] & wv_reg[1]) ^ (wv_reg[0] & wv_reg[2]) ^ (wv_reg[1] & wv_reg[2]);
    t2    = s0 + maj;
    w_new = (rotr(w_reg[14], 17) ^ rotr(w_reg[14], 19) ^ (w_reg[14] >> 10)) + w_reg[9]
          + (rotr(w_reg[1], 7) ^ rotr(w_reg[1], 18) ^ (w_reg[1] >> 3)) + w_reg[0];
  end

  always_comb begin
    st_next = st_reg;
    case (st_reg)
      S_IDLE:  if (go) st_next = S_LOAD;
      S_LOAD:  st_next = S_ROUND;
      S_ROUND: if (rnd_reg == 6'd63) st_next = S_ADD;
      S_ADD:   st_next = (blk_reg == 2'd3) ? S_DONE : S_LOAD;
      default: st_next = st_reg;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      st_reg    <= S_IDLE;
      blk_reg   <= '0;
      rnd_reg   <= '0;
      inner_reg <= '0;
      hmac_reg  <= '0;
      for (int i = 0; i < 8; i++) begin
        hv_reg[i] <= '0;
        wv_reg[i] <= '0;
      end
      for (int i = 0; i < 16; i++) w_reg[i] <= '0;
    end else begin
      st_reg <= st_next;
      case (st_reg)
        S_IDLE: if (go) begin
          blk_reg <= '0;
          for (int i = 0; i < 8; i++) hv_reg[i] <= IV[255-32*i -: 32];
        end
        S_LOAD: begin
          for (int i = 0; i < 16; i++) w_reg[i] <= blk_word[i];
          for (int i = 0; i < 8; i++) wv_reg[i] <= hv_reg[i];
          rnd_reg <= '0;
        end
        S_ROUND: begin
          wv_reg[0] <= t1 + t2;
          wv_reg[1] <= wv_reg[0];
          wv_reg[2] <= wv_reg[1];
          wv_reg[3] <= wv_reg[2];
          wv_reg[4] <= wv_reg[3] + t1;
          wv_reg[5] <= wv_reg[4];
          wv_reg[6] <= wv_reg[5];
          wv_reg[7] <= wv_reg[6];
          for (int i = 0; i < 15; i++) w_reg[i] <= w_reg[i+1];
          w_reg[15] <= w_new;
          rnd_reg   <= rnd_reg + 6'd1;
        end
        S_ADD: begin
          blk_reg <= blk_reg + 2'd1;
          // Inner hash finished: keep it and restart the chain for the outer hash.
          if (blk_reg == 2'd1) begin
            inner_reg <= hsum_flat;
            for (int i = 0; i < 8; i++) hv_reg[i] <= IV[255-32*i -: 32];
          end else begin
            for (int i = 0; i < 8; i++) hv_reg[i] <= hsum[i];
            if (blk_reg == 2'd3) hmac_reg <= hsum_flat;
          end
        end
        default: ;
      endcase
    end
  end

  assign data_available = (st_reg == S_DONE);
  assign hmac           = hmac_reg;

endmodule

// File: rtl/tag_ct_compare.sv
// Byte-serial tag comparator: always walks all 32 bytes, masking bytes past
// tag_len, so timing never depends on the tag length or the mismatch position.
module tag_ct_compare
  import hmac_verify_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             en,
  input  logic [TAG_W-1:0] hmac,
  input  logic [TAG_W-1:0] tag,
  input  logic [5:0]       tag_len,
  output logic             done,
  output logic             diff_nz
);

  logic [4:0] idx_reg;
  logic [7:0] diff_reg, diff_next;
  logic [7:0] hmac_byte [HMAC_BYTES];
  logic [7:0] tag_byte  [HMAC_BYTES];
  logic       in_range;

  genvar gi;
  for (gi = 0; gi < HMAC_BYTES; gi++) begin : g_bytes
    assign hmac_byte[gi] = hmac[TAG_W-1-8*gi -: 8];
    assign tag_byte[gi]  = tag[TAG_W-1-8*gi -: 8];
  end

  always_comb begin
    in_range  = ({1'b0, idx_reg} < tag_len);
    diff_next = diff_reg | ((hmac_byte[idx_reg] ^ tag_byte[idx_reg]) & {8{in_range}});
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idx_reg  <= '0;
      diff_reg <= '0;
    end else if (clr) begin
      idx_reg  <= '0;
      diff_reg <= '0;
    end else if (en) begin
      idx_reg  <= idx_reg + 5'd1;
      diff_reg <= diff_next;
    end
  end

  assign done    = en & (idx_reg == 5'd31);
  assign diff_nz = |diff_reg;

endmodule

// File: rtl/hmac_sha256_verify.sv
// Receiver-side HMAC-SHA256 tag check: recompute the MAC with the embedded
// core, compare it to the received tag in constant time, return a verdict.
module hmac_sha256_verify
  import hmac_verify_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MIN_TAG_BYTES  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [KEY_W-1:0]  key,
  input  logic [DATA_W-1:0] data,
  input  logic [TAG_W-1:0]  tag,
  input  logic [5:0]        tag_len,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_match,
  output logic              resp_error,
  output logic              busy
);

  localparam int               CNT_W    = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [5:0]       LEN_MIN  = 6'(MIN_TAG_BYTES);
  localparam logic [5:0]       LEN_MAX  = 6'(HMAC_BYTES);

  state_t state_reg, state_next;

  logic [KEY_W-1:0]  key_reg;
  logic [DATA_W-1:0] data_reg;
  logic [TAG_W-1:0]  tag_reg;
  logic [TAG_W-1:0]  hmac_reg;
  logic [5:0]        tag_len_reg;
  logic              err_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              core_clr_reg;

  logic              accept, resp_done, tag_len_ok, run_timeout;
  logic              core_go, core_rst_n, core_da;
  logic [TAG_W-1:0]  core_hmac;
  logic              cmp_clr, cmp_en, cmp_done, diff_nz;

  // Core is held in reset everywhere but RUN, so no stale data_available survives.
  assign core_rst_n = ~(RST | core_clr_reg);

  hmac_sha256 u_core (
    .CLK            (CLK),
    .RST            (core_rst_n),
    .go             (core_go),
    .key            (key_reg),
    .data           (data_reg),
    .data_available (core_da),
    .hmac           (core_hmac)
  );

  tag_ct_compare u_cmp (
    .CLK     (CLK),
    .RST     (RST),
    .clr     (cmp_clr),
    .en      (cmp_en),
    .hmac    (hmac_reg),
    .tag     (tag_reg),
    .tag_len (tag_len_reg),
    .done    (cmp_done),
    .diff_nz (diff_nz)
  );

  always_comb begin
    state_next  = state_reg;
    req_ready   = (state_reg == IDLE) & ~RST;
    accept      = req_valid & req_ready;
    resp_valid  = (state_reg == RESP);
    resp_done   = resp_valid & resp_ready;
    resp_match  = resp_valid & ~err_reg & ~diff_nz;
    resp_error  = resp_valid & err_reg;
    busy        = (state_reg != IDLE);
    core_go     = (state_reg == RUN);
    cmp_en      = (state_reg == CMP);
    cmp_clr     = (state_reg == ERRCHK) | resp_done;
    tag_len_ok  = (tag_len_reg >= LEN_MIN) && (tag_len_reg <= LEN_MAX);
    run_timeout = (state_reg == RUN) & ~core_da & (cnt_reg == CNT_LAST);
    case (state_reg)
      IDLE:    if (accept) state_next = ERRCHK;
      ERRCHK:  state_next = tag_len_ok ? CLEAR : RESP;
      CLEAR:   state_next = RUN;
      RUN: begin
        if (core_da)          state_next = CMP;
        else if (run_timeout) state_next = RESP;
      end
      CMP:     if (cmp_done) state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg    <= IDLE;
      key_reg      <= '0;
      data_reg     <= '0;
      tag_reg      <= '0;
      hmac_reg     <= '0;
      tag_len_reg  <= '0;
      err_reg      <= 1'b0;
      cnt_reg      <= '0;
      core_clr_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      core_clr_reg <= (state_next != RUN);
      cnt_reg      <= (state_reg == RUN) ? cnt_reg + 1'b1 : '0;
      if (accept) begin
        key_reg     <= key;
        data_reg    <= data;
        tag_reg     <= tag;
        tag_len_reg <= tag_len;
        err_reg     <= 1'b0;
      end
      if ((state_reg == ERRCHK) && !tag_len_ok) err_reg <= 1'b1;
      if (run_timeout) err_reg <= 1'b1;
      if ((state_reg == RUN) && core_da) hmac_reg <= core_hmac;
      // Scrub all secret material once the verdict has been consumed.
      if (resp_done) begin
        key_reg     <= '0;
        data_reg    <= '0;
        tag_reg     <= '0;
        hmac_reg    <= '0;
        tag_len_reg <= '0;
        err_reg     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hmac_sha256_verify.sv
// Directed bench for hmac_sha256_verify using RFC 4231 vectors 1 and 2.
module tb_hmac_sha256_verify;

  localparam logic [511:0] C1_KEY  = {{20{8'h0b}}, 352'd0};
  localparam logic [511:0] C1_DATA = {64'h4869205468657265, 8'h80, 376'd0, 64'h240};
  localparam logic [255:0] C1_TAG  = 256'hb0344c61d8db38535ca8afceaf0bf12b881dc200c9833da726e9376c2e32cff7;
  localparam logic [511:0] C2_KEY  = {32'h4a656665, 480'd0};
  localparam logic [511:0] C2_DATA = {224'h7768617420646f2079612077616e7420666f72206e6f7468696e673f,
                                      8'h80, 216'd0, 64'h2e0};
  localparam logic [255:0] C2_TAG  = {128'h5bdcc146bf60754e6a042426089575c7, {16{8'hff}}};

  // Cycle index (accept cycle = 0) of the first resp_valid cycle:
  // legal = ERRCHK + CLEAR + 266 RUN + 32 CMP, then RESP.
  localparam int LAT_LEGAL   = 301;
  localparam int LAT_ILLEGAL = 2;
  localparam int LAT_TIMEOUT = 7;
  localparam int CMP_BYTE10  = 279;
  localparam int WAIT_LIMIT  = 2000;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic         RST;
  logic         req_valid, req_ready, resp_valid, resp_ready, resp_match, resp_error, busy;
  logic         req_valid_t, req_ready_t, resp_valid_t, resp_ready_t, resp_match_t, resp_error_t, busy_t;
  logic [511:0] key, data;
  logic [255:0] tag;
  logic [5:0]   tag_len;

  int checks = 0;
  int errors = 0;
  int m;
  bit go_seen;

  hmac_sha256_verify dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
    .key(key), .data(data), .tag(tag), .tag_len(tag_len),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_match(resp_match),
    .resp_error(resp_error), .busy(busy)
  );

  hmac_sha256_verify #(.TIMEOUT_CYCLES(4)) dut_t (
    .CLK(CLK), .RST(RST), .req_valid(req_valid_t), .req_ready(req_ready_t),
    .key(key), .data(data), .tag(tag), .tag_len(tag_len),
    .resp_valid(resp_valid_t), .resp_ready(resp_ready_t), .resp_match(resp_match_t),
    .resp_error(resp_error_t), .busy(busy_t)
  );

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Present a request on the selected instance, wait for acceptance, then wait
  // for resp_valid (or stop at cycle index stop_at when nonzero).
  task automatic issue(input bit sel, input int stop_at, output int lat, output bit go_any);
    int n;
    @(negedge CLK);
    if (sel) req_valid_t = 1'b1; else req_valid = 1'b1;
    n = 0;
    while (!(sel ? req_ready_t : req_ready) && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check("accept_bound", 32'(n < 100), 32'd1);
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    req_valid_t = 1'b0;
    lat = 1;
    go_any = 1'b0;
    while (lat < WAIT_LIMIT) begin
      go_any = go_any | (sel ? dut_t.core_go : dut.core_go);
      if (sel ? resp_valid_t : resp_valid) break;
      if (stop_at != 0 && lat == stop_at) break;
      @(posedge CLK);
      #1;
      lat++;
    end
    check("resp_bound", 32'(lat < WAIT_LIMIT), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    req_valid = 1'b0;  req_valid_t = 1'b0;
    resp_ready = 1'b1; resp_ready_t = 1'b1;
    key = '0; data = '0; tag = '0; tag_len = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_match", 32'(resp_match), 32'd0);
    check("rst_resp_error", 32'(resp_error), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check("post_rst_req_ready", 32'(req_ready), 32'd1);

    // Case 1, full 32-byte tag
    key = C1_KEY; data = C1_DATA; tag = C1_TAG; tag_len = 6'd32;
    issue(1'b0, 0, m, go_seen);
    check("c1_latency", 32'(m), 32'(LAT_LEGAL));
    check("c1_match", 32'(resp_match), 32'd1);
    check("c1_error", 32'(resp_error), 32'd0);
    check("c1_req_ready_in_resp", 32'(req_ready), 32'd0);

    // Single-bit tag corruption at either end: same verdict, same latency
    tag = C1_TAG ^ 256'd1;
    issue(1'b0, 0, m, go_seen);
    check("flip0_latency", 32'(m), 32'(LAT_LEGAL));
    check("flip0_match", 32'(resp_match), 32'd0);
    check("flip0_error", 32'(resp_error), 32'd0);
    tag = C1_TAG ^ (256'd1 << 255);
    issue(1'b0, 0, m, go_seen);
    check("flip255_latency", 32'(m), 32'(LAT_LEGAL));
    check("flip255_match", 32'(resp_match), 32'd0);

    // Case 1 then case 2 back-to-back, case 2 verdict held with resp_ready low
    tag = C1_TAG;
    issue(1'b0, 0, m, go_seen);
    check("b2b_c1_match", 32'(resp_match), 32'd1);
    @(posedge CLK);
    #1;
    resp_ready = 1'b0;
    check("b2b_done_valid", 32'(resp_valid), 32'd0);
    check("b2b_done_req_ready", 32'(req_ready), 32'd1);
    key = C2_KEY; data = C2_DATA; tag = C2_TAG; tag_len = 6'd16;
    issue(1'b0, 0, m, go_seen);
    check("c2_latency", 32'(m), 32'(LAT_LEGAL));
    for (int i = 0; i < 5; i++) begin
      check("c2_hold_valid", 32'(resp_valid), 32'd1);
      check("c2_hold_match", 32'(resp_match), 32'd1);
      check("c2_hold_error", 32'(resp_error), 32'd0);
      @(posedge CLK);
      #1;
    end
    resp_ready = 1'b1;
    @(posedge CLK);
    #1;
    check("c2_done_valid", 32'(resp_valid), 32'd0);
    check("c2_done_req_ready", 32'(req_ready), 32'd1);
    check("c2_tag_zeroized", 32'(dut.tag_reg == '0), 32'd1);

    // Illegal tag lengths on both sides of the legal range
    key = C1_KEY; data = C1_DATA; tag = C1_TAG; tag_len = 6'd15;
    issue(1'b0, 0, m, go_seen);
    check("len15_latency", 32'(m), 32'(LAT_ILLEGAL));
    check("len15_error", 32'(resp_error), 32'd1);
    check("len15_match", 32'(resp_match), 32'd0);
    check("len15_go", 32'(go_seen), 32'd0);
    tag_len = 6'd33;
    issue(1'b0, 0, m, go_seen);
    check("len33_latency", 32'(m), 32'(LAT_ILLEGAL));
    check("len33_error", 32'(resp_error), 32'd1);
    check("len33_match", 32'(resp_match), 32'd0);
    check("len33_go", 32'(go_seen), 32'd0);

    // Core timeout on the TIMEOUT_CYCLES=4 instance
    tag_len = 6'd32;
    issue(1'b1, 0, m, go_seen);
    check("timeout_latency", 32'(m), 32'(LAT_TIMEOUT));
    check("timeout_error", 32'(resp_error_t), 32'd1);
    check("timeout_match", 32'(resp_match_t), 32'd0);
    check("timeout_go", 32'(go_seen), 32'd1);

    // Reset in the middle of the byte compare
    issue(1'b0, CMP_BYTE10, m, go_seen);
    check("mid_cmp_busy", 32'(busy), 32'd1);
    check("mid_cmp_valid", 32'(resp_valid), 32'd0);
    RST = 1'b1;
    #1;
    check("rst_cmp_busy", 32'(busy), 32'd0);
    check("rst_cmp_valid", 32'(resp_valid), 32'd0);
    check("rst_cmp_match", 32'(resp_match), 32'd0);
    check("rst_cmp_error", 32'(resp_error), 32'd0);
    check("rst_cmp_req_ready", 32'(req_ready), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check("rst_cmp_release_ready", 32'(req_ready), 32'd1);
    issue(1'b0, 0, m, go_seen);
    check("after_rst_latency", 32'(m), 32'(LAT_LEGAL));
    check("after_rst_match", 32'(resp_match), 32'd1);
    check("after_rst_error", 32'(resp_error), 32'd0);

    @(posedge CLK);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
